// File: rtl/bnn_seq_lin_layer.sv
// bnn_seq_lin_layer
//
// Time-multiplexed binary fully-connected layer. Each output neuron is the
// XNOR-popcount of the registered input vector against that neuron's weight
// column. The column is processed PAR bits per cycle, and the result is then
// binarised against a per-neuron threshold. One neuron is finished every
// CHUNKS cycles. A full vector takes OSIZE_FEAT*CHUNKS cycles.
//
// Ports
//   clk_i, rst_ni      clock (rising edge), asynchronous active-low reset
//   in_valid_i         input vector valid
//   in_ready_o         block can accept a vector (IDLE only)
//   layer_i            binarised input vector (1 = +1, 0 = -1)
//   weights_i          weight for input i, neuron o at bit i*OSIZE_FEAT+o
//   threshold_i        per-neuron unsigned threshold, N_BITCONV bits each
//   sign_i             per-neuron compare mode:
//                        01 p>=t, 10 p<=t, 00 force 0, 11 force 1
//   out_valid_o        results valid (DONE)
//   out_ready_i        consumer accepts results
//   layer_o            binarised outputs
//   score_o            raw popcounts, N_BITCONV bits per neuron
//   busy_o             high while neurons are being computed (RUN)
//
// weights_i, threshold_i and sign_i are read live during RUN. They must be
// held stable from input acceptance until out_valid_o.

module bnn_seq_lin_layer #(
  parameter int ISIZE_FEAT = 288,
  parameter int OSIZE_FEAT = 64,
  parameter int PAR        = 32,
  parameter int N_BITCONV  = 10
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic                             in_valid_i,
  output logic                             in_ready_o,
  input  logic [ISIZE_FEAT-1:0]            layer_i,
  input  logic [ISIZE_FEAT*OSIZE_FEAT-1:0] weights_i,
  input  logic [OSIZE_FEAT*N_BITCONV-1:0]  threshold_i,
  input  logic [OSIZE_FEAT*2-1:0]          sign_i,
  output logic                             out_valid_o,
  input  logic                             out_ready_i,
  output logic [OSIZE_FEAT-1:0]            layer_o,
  output logic [OSIZE_FEAT*N_BITCONV-1:0]  score_o,
  output logic                             busy_o
);

  localparam int CHUNKS = (ISIZE_FEAT + PAR - 1) / PAR;
  localparam int CW     = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
  localparam int NW     = (OSIZE_FEAT > 1) ? $clog2(OSIZE_FEAT) : 1;
  localparam int PADW   = CHUNKS * PAR;

  if (N_BITCONV < $clog2(ISIZE_FEAT + 1)) begin : g_bitconv_chk
    $error("N_BITCONV too small to hold a popcount of ISIZE_FEAT bits");
  end
  if (PAR < 1 || PAR > ISIZE_FEAT) begin : g_par_chk
    $error("PAR must be in 1..ISIZE_FEAT");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                 state_q, state_d;
  logic [ISIZE_FEAT-1:0]  layer_reg;
  logic [N_BITCONV-1:0]   acc;
  logic [CW-1:0]          chunk;
  logic [NW-1:0]          neuron;

  // The input vector, the current neuron's weight column and a valid-bit mask
  // are all padded to a whole number of chunks. This lets a chunk be sliced
  // uniformly. Padding bits are zero in the mask, so they never count.
  logic [PADW-1:0] layer_pad, w_col, valid_mask;

  for (genvar i = 0; i < PADW; i++) begin : g_col
    if (i < ISIZE_FEAT) begin : g_real
      logic [OSIZE_FEAT-1:0] w_row;
      assign w_row         = weights_i[i*OSIZE_FEAT +: OSIZE_FEAT];
      assign w_col[i]      = w_row[neuron];
      assign layer_pad[i]  = layer_reg[i];
      assign valid_mask[i] = 1'b1;
    end else begin : g_pad
      assign w_col[i]      = 1'b0;
      assign layer_pad[i]  = 1'b0;
      assign valid_mask[i] = 1'b0;
    end
  end

  logic [PAR-1:0]       match_bits;
  logic [N_BITCONV-1:0] chunk_pop, sum, thr;
  logic [1:0]           sgn;
  logic                 bin, last_chunk, last_neuron;

  assign last_chunk  = (chunk == CW'(CHUNKS - 1));
  assign last_neuron = (neuron == NW'(OSIZE_FEAT - 1));
  assign thr         = threshold_i[int'(neuron)*N_BITCONV +: N_BITCONV];
  assign sgn         = sign_i[int'(neuron)*2 +: 2];

  always_comb begin
    // NOTE: every variable gets a default before the loop/case so that no
    // path leaves it unassigned; an unassigned path would infer a latch.
    match_bits = ~(layer_pad[int'(chunk)*PAR +: PAR] ^ w_col[int'(chunk)*PAR +: PAR])
                 & valid_mask[int'(chunk)*PAR +: PAR];
    chunk_pop  = '0;
    for (int j = 0; j < PAR; j++) begin
      chunk_pop = chunk_pop + N_BITCONV'(match_bits[j]);
    end
    sum = acc + chunk_pop;
    bin = 1'b0;
    unique case (sgn)
      2'b01:   bin = (sum >= thr);
      2'b10:   bin = (sum <= thr);
      2'b11:   bin = 1'b1;
      default: bin = 1'b0;
    endcase
  end

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk_i or negedge rst_ni) begin
    // NOTE: clocked state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of statement or block order.
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (in_valid_i)                 state_d = RUN;
      RUN:     if (last_chunk && last_neuron)  state_d = DONE;
      DONE:    if (out_ready_i)                state_d = IDLE;
      default:                                 state_d = IDLE;
    endcase
  end

  assign in_ready_o  = (state_q == IDLE);
  assign busy_o      = (state_q == RUN);
  assign out_valid_o = (state_q == DONE);

  // ----------------------------------------------------------- datapath
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      layer_reg <= '0;
      acc       <= '0;
      chunk     <= '0;
      neuron    <= '0;
      layer_o   <= '0;
      score_o   <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid_i) begin
            layer_reg <= layer_i;
            acc       <= '0;
            chunk     <= '0;
            neuron    <= '0;
          end
        end
        RUN: begin
          if (last_chunk) begin
            score_o[int'(neuron)*N_BITCONV +: N_BITCONV] <= sum;
            layer_o[neuron] <= bin;
            acc    <= '0;
            chunk  <= '0;
            neuron <= last_neuron ? '0 : neuron + NW'(1);
          end else begin
            acc   <= sum;
            chunk <= chunk + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
